pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//  Registered program-counter generator for the pipelined RV32 core; successor to the combinational next-PC mux.
//  Holds the fetch PC and advances it by 4 on each accepted fetch.
//  Resolves branches and jumps reported by execute; a taken one redirects fetch and flushes younger stages.
//  Parametrised in XLEN and vectors; counts redirects; traps misaligned targets.
// PARAMETERS
//  XLEN          32            datapath width (all PC/imm/ALU buses)
//  RESET_VECTOR  32'h0000_0000 PC loaded by reset
//  TRAP_VECTOR   32'h0000_0100 PC loaded on misaligned-target trap
//  HIST_DEPTH    8             redirect history entries, power of 2 (used only with PC_HIST_EN)
// PORTS
//  clk          in   1                  core clock, rising edge
//  rst_n        in   1                  asynchronous, active-low reset
//  if_ready     in   1                  fetch accepts pc this cycle
//  ex_valid     in   1                  execute stage holds a valid instruction
//  ex_pc        in   XLEN               PC of the execute-stage instruction
//  ex_imm       in   XLEN               sign-extended branch/JAL immediate
//  ex_branch    in   3                  000 none, 001 taken-if-!zero, 010 taken-if-zero, 011 JAL, 100 JALR
//  ex_zero      in   1                  ALU zero flag for the execute-stage instruction
//  ex_alu       in   XLEN               ALU result (JALR target before masking)
//  pc           out  XLEN               current fetch PC (registered)
//  pc_valid     out  1                  pc is a valid fetch request
//  ex_pc_plus4  out  XLEN               ex_pc + 4, link value for JAL/JALR
//  flush        out  1                  kill IF/ID this cycle (combinational)
//  misalign_exc out  1                  taken target with bits[1:0] != 0 (combinational)
//  redirect_cnt out  32                 taken-redirect count, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_VECTOR, pc_valid=0, redirect_cnt=0, history cleared.
//  - First clk edge after rst_n=1: pc_valid<=1, pc unchanged. pc_valid then stays 1 until the next reset.
//  - Taken conditions, qualified by ex_valid:
//    - 001 && !ex_zero; 010 && ex_zero; 011 always; 100 always. Codes 101-111 are never taken.
//  - Targets:
//    - 001/010/011: ex_pc + ex_imm, mod 2^XLEN.
//    - 100: ex_alu & ~1.
//  - Output timing:
//    - redirect = taken: flush = redirect, same cycle.
//    - misalign_exc = redirect && target[1:0] != 0, same cycle.
//  - PC update priority per edge:
//    1. misalign_exc: pc <= TRAP_VECTOR.
//    2. redirect: pc <= target.
//    3. pc_valid && if_ready: pc <= pc + 4, wraps at 2^XLEN.
//    4. Otherwise hold.
//  - Redirect beats a fetch stall: with if_ready=0 and redirect=1, pc still loads the target.
//  - redirect_cnt: +1 per redirect, including trapped ones; holds at all-ones.
//  - Not-taken branch: no flush; pc follows the if_ready rule.
//  - Reset asserted mid-redirect: the async reset wins immediately; no partial update.
//  - Latency: redirect takes effect on pc one cycle after ex_valid.
// CONFIGURATION
//  PC_HIST_EN defined:
//   - Adds ports hist_idx (in, log2(HIST_DEPTH)), hist_src (out, XLEN), hist_tgt (out, XLEN).
//   - Every redirect writes {ex_pc, target} to a circular buffer at wr_ptr, then increments wr_ptr (wraps).
//   - hist_idx=0 reads the newest entry; hist_idx=k reads the entry k writes older.
//   - Read is combinational; never-written entries read 0.
//   - Reset clears wr_ptr and all entries.
//  PC_HIST_EN undefined: no history ports, buffer or pointer logic.
//   - All other behaviour is identical in both builds.
// TESTING
//  T1 reset: rst_n=0 -> pc=0, pc_valid=0, cnt=0; release + 1 edge -> pc_valid=1, pc=0.
//  T2 sequential: if_ready=1 for 3 edges -> pc 0->4->8->C; if_ready=0 -> pc holds C.
//  T3 BEQ taken: ex_branch=010, ex_zero=1, ex_pc=0x40, ex_imm=0xFFFFFFF0 -> flush=1, next pc=0x30, cnt+1.
//  T4 BNE not taken during stall: 001, zero=1, if_ready=0 -> flush=0, pc holds.
//  T4 JALR: ex_alu=0x1235 -> pc=0x1234, no exc, ex_pc_plus4=ex_pc+4.
//  T5 misaligned JAL: ex_pc=0x100, ex_imm=0x6 -> misalign_exc=1, flush=1, next pc=0x100 (TRAP_VECTOR).
//  T6 PC_HIST_EN: 9 redirects with HIST_DEPTH=8 -> hist_idx=0 gives 9th, hist_idx=7 gives 2nd; async reset mid-run -> all 0.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Registered fetch-PC generator: sequential advance, branch/jump redirect, misaligned-target trap.
// Optional redirect history buffer enabled by defining PC_HIST_EN.
module pc_gen_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
`ifdef PC_HIST_EN
  ,
  parameter int unsigned     HIST_DEPTH   = 8
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_ready,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [2:0]      ex_branch,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_alu,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] ex_pc_plus4,
  output logic            flush,
  output logic            misalign_exc,
  output logic [31:0]     redirect_cnt
`ifdef PC_HIST_EN
  ,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [XLEN-1:0]               hist_src,
  output logic [XLEN-1:0]               hist_tgt
`endif
);

  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BEQ  = 3'b010;
  localparam logic [2:0] BR_JAL  = 3'b011;
  localparam logic [2:0] BR_JALR = 3'b100;

  logic            taken;
  logic            redirect;
  logic [XLEN-1:0] target;

  // Branch resolution and target selection for the execute-stage instruction
  always_comb begin
    taken  = 1'b0;
    target = ex_pc + ex_imm;
    case (ex_branch)
      BR_BNE:  taken = !ex_zero;
      BR_BEQ:  taken = ex_zero;
      BR_JAL:  taken = 1'b1;
      BR_JALR: begin
        taken  = 1'b1;
        target = ex_alu & ~XLEN'(1);
      end
      default: taken = 1'b0;
    endcase
  end

  assign redirect     = ex_valid && taken;
  assign flush        = redirect;
  assign misalign_exc = redirect && (target[1:0] != 2'b00);
  assign ex_pc_plus4  = ex_pc + XLEN'(4);

  // Fetch PC: trap beats redirect, redirect beats sequential advance (even when stalled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VECTOR;
      pc_valid <= 1'b0;
    end else begin
      pc_valid <= 1'b1;
      if (misalign_exc) begin
        pc <= TRAP_VECTOR;
      end else if (redirect) begin
        pc <= target;
      end else if (pc_valid && if_ready) begin
        pc <= pc + XLEN'(4);
      end
    end
  end

  // Saturating count of taken redirects, trapped ones included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
    end else if (redirect && (redirect_cnt != '1)) begin
      redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

`ifdef PC_HIST_EN
  localparam int unsigned HAW = $clog2(HIST_DEPTH);

  logic [XLEN-1:0] hist_src_q [HIST_DEPTH];
  logic [XLEN-1:0] hist_tgt_q [HIST_DEPTH];
  logic [HAW-1:0]  wr_ptr;
  logic [HAW-1:0]  rd_ptr;

  // Circular redirect log; wr_ptr always points at the next slot to overwrite
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
        hist_src_q[HAW'(i)] <= '0;
        hist_tgt_q[HAW'(i)] <= '0;
      end
    end else if (redirect) begin
      hist_src_q[wr_ptr] <= ex_pc;
      hist_tgt_q[wr_ptr] <= target;
      wr_ptr             <= wr_ptr + HAW'(1);
    end
  end

  // Index 0 is the newest entry, so read backwards from the write pointer
  assign rd_ptr   = wr_ptr - HAW'(1) - hist_idx;
  assign hist_src = hist_src_q[rd_ptr];
  assign hist_tgt = hist_tgt_q[rd_ptr];
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed literal checks plus randomized run against a behavioural model.
// Define PC_HIST_EN to also exercise the redirect history buffer.
module tb_pc_gen_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TV   = 32'h0000_0100;
  localparam int unsigned HD   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_ready = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic [2:0]  ex_branch = '0;
  logic        ex_zero = 1'b0;
  logic [31:0] ex_alu = '0;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] ex_pc_plus4;
  logic        flush;
  logic        misalign_exc;
  logic [31:0] redirect_cnt;
`ifdef PC_HIST_EN
  logic [2:0]  hist_idx = '0;
  logic [31:0] hist_src;
  logic [31:0] hist_tgt;
`endif

  pc_gen_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)
`ifdef PC_HIST_EN
    , .HIST_DEPTH(HD)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_alu(ex_alu), .pc(pc), .pc_valid(pc_valid), .ex_pc_plus4(ex_pc_plus4),
    .flush(flush), .misalign_exc(misalign_exc), .redirect_cnt(redirect_cnt)
`ifdef PC_HIST_EN
    , .hist_idx(hist_idx), .hist_src(hist_src), .hist_tgt(hist_tgt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural rules written directly, history kept newest-first
  logic [31:0] m_pc = RV;
  logic        m_valid = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_src_q[$];
  logic [31:0] m_tgt_q[$];
  logic        m_red;
  logic [31:0] m_tgt;

  function automatic logic model_taken(input logic v, input logic [2:0] br, input logic z);
    return v && ((br == 3'd3) || (br == 3'd4) || (br == 3'd1 && !z) || (br == 3'd2 && z));
  endfunction

  function automatic logic [31:0] model_target(input logic [2:0] br, input logic [31:0] p,
                                               input logic [31:0] imm, input logic [31:0] alu);
    if (br == 3'd4) return {alu[31:1], 1'b0};
    return p + imm;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RV; m_valid = 1'b0; m_cnt = '0;
      m_src_q.delete(); m_tgt_q.delete();
    end else begin
      m_red = model_taken(ex_valid, ex_branch, ex_zero);
      m_tgt = model_target(ex_branch, ex_pc, ex_imm, ex_alu);
      if (m_red) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_src_q.push_front(ex_pc);
        m_tgt_q.push_front(m_tgt);
        if (m_src_q.size() > HD) begin
          void'(m_src_q.pop_back());
          void'(m_tgt_q.pop_back());
        end
      end
      if (m_red && m_tgt[1:0] != 2'b00) m_pc = TV;
      else if (m_red)                   m_pc = m_tgt;
      else if (m_valid && if_ready)     m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic        e_red;
    logic [31:0] e_tgt;
    e_red = model_taken(ex_valid, ex_branch, ex_zero);
    e_tgt = model_target(ex_branch, ex_pc, ex_imm, ex_alu);
    check("pc", pc, m_pc);
    check("pc_valid", 32'(pc_valid), 32'(m_valid));
    check("redirect_cnt", redirect_cnt, m_cnt);
    check("flush", 32'(flush), 32'(e_red));
    check("misalign_exc", 32'(misalign_exc), 32'(e_red && e_tgt[1:0] != 2'b00));
    check("ex_pc_plus4", ex_pc_plus4, ex_pc + 32'd4);
`ifdef PC_HIST_EN
    check("hist_src", hist_src, (int'(hist_idx) < m_src_q.size()) ? m_src_q[hist_idx] : 32'h0);
    check("hist_tgt", hist_tgt, (int'(hist_idx) < m_tgt_q.size()) ? m_tgt_q[hist_idx] : 32'h0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] br, input logic z,
                       input logic [31:0] p, input logic [31:0] imm, input logic [31:0] alu,
                       input logic rdy);
    ex_valid = v; ex_branch = br; ex_zero = z; ex_pc = p; ex_imm = imm; ex_alu = alu;
    if_ready = rdy;
  endtask

  initial begin
    // T1 reset
    repeat (2) @(negedge clk);
    check("T1 pc reset", pc, 32'h0);
    check("T1 pc_valid reset", 32'(pc_valid), 32'h0);
    check("T1 cnt reset", redirect_cnt, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("T1 pc_valid after release", 32'(pc_valid), 32'h1);
    check("T1 pc after release", pc, 32'h0);

    // T2 sequential fetch then stall
    @(posedge clk); #1;
    if_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("T2 pc after 3 fetches", pc, 32'hC);
    if_ready = 1'b0;
    step();
    @(negedge clk);
    check("T2 pc held on stall", pc, 32'hC);

    // T3 BEQ taken with negative offset
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 1'b1, 32'h40, 32'hFFFF_FFF0, 32'h0, 1'b1);
    @(negedge clk);
    check("T3 flush", 32'(flush), 32'h1);
    step();
    drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("T3 pc", pc, 32'h30);
    check("T3 cnt", redirect_cnt, 32'h1);

    // T4 BNE not taken during stall
    @(posedge clk); #1;
    drive(1'b1, 3'b001, 1'b1, 32'h80, 32'h40, 32'h0, 1'b0);
    @(negedge clk);
    check("T4 bne flush", 32'(flush), 32'h0);
    step();
    @(negedge clk);
    check("T4 bne pc held", pc, 32'h30);

    // T4 JALR clears bit 0
    @(posedge clk); #1;
    drive(1'b1, 3'b100, 1'b0, 32'h200, 32'h0, 32'h1235, 1'b0);
    @(negedge clk);
    check("T4 jalr exc", 32'(misalign_exc), 32'h0);
    check("T4 jalr link", ex_pc_plus4, 32'h204);
    step();
    drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("T4 jalr pc", pc, 32'h1234);
    check("T4 jalr cnt", redirect_cnt, 32'h2);

    // T5 misaligned JAL traps
    @(posedge clk); #1;
    drive(1'b1, 3'b011, 1'b0, 32'h100, 32'h6, 32'h0, 1'b1);
    @(negedge clk);
    check("T5 exc", 32'(misalign_exc), 32'h1);
    check("T5 flush", 32'(flush), 32'h1);
    step();
    drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("T5 pc trap", pc, 32'h100);
    check("T5 cnt", redirect_cnt, 32'h3);

    // Randomized traffic, with one async reset landing on a redirect
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 1'($urandom),
            $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'h0000_FFFC),
            $urandom, $urandom_range(0, 3) != 0);
`ifdef PC_HIST_EN
      hist_idx = 3'($urandom);
`endif
      if (i == 1500) begin
        drive(1'b1, 3'b011, 1'b0, 32'h4000, 32'h40, 32'h0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-reset pc", pc, RV);
        check("mid-reset cnt", redirect_cnt, 32'h0);
        step();
        rst_n = 1'b1;
      end
    end

`ifdef PC_HIST_EN
    // T6 nine redirects into an eight-entry history
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 3'b011, 1'b0, 32'(k) * 32'h10, 32'h1000, 32'h0, 1'b0);
      step();
    end
    drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    hist_idx = 3'd0;
    @(negedge clk);
    check("T6 newest src", hist_src, 32'h90);
    check("T6 newest tgt", hist_tgt, 32'h1090);
    hist_idx = 3'd7;
    @(negedge clk);
    check("T6 oldest src", hist_src, 32'h20);
    check("T6 oldest tgt", hist_tgt, 32'h1020);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("T6 reset src", hist_src, 32'h0);
    check("T6 reset tgt", hist_tgt, 32'h0);
    step();
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
